// File: rtl/nroot_iter.sv
// Iterative n-th root of an IEEE-754-format radicand: exponent divided by N, mantissa found bit by bit.
// Define NROOT_ROUND_EN to add a round pass plus sticky test and round-to-nearest-even; otherwise truncates.
module nroot_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int N_W   = 5,
    parameter int GUARD = 4
) (
    input  logic                   CLK2,
    input  logic                   RST,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [N_W-1:0]         N,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   invalid,
    output logic                   underflow
);
    localparam int FPW  = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
`ifdef NROOT_ROUND_EN
    localparam int RB   = 1;
`else
    localparam int RB   = 0;
`endif
    localparam int YF   = MAN_W + RB;
    localparam int PF   = MAN_W + 1 + GUARD;
    localparam int PW   = PF + YF + 2;
    localparam int IW   = $clog2(YF + 1);
    localparam int CW   = (N_W > $clog2(EXP_W + 2)) ? N_W : $clog2(EXP_W + 2);
    localparam logic [FPW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_DIVEXP, S_TRIAL, S_MUL, S_CMP, S_PACK, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [FPW-1:0]     a_q, a_d, sres_q, sres_d, result_q, result_d;
    logic [N_W-1:0]     n_q, n_d, rem_q, rem_d, r_q, r_d, k_q, k_d;
    logic [EXP_W-1:0]   dq_q, dq_d, qb_q, qb_d;
    logic [YF:0]        y_q, y_d, yt_q, yt_d, yt_c;
    logic [PF:0]        p_q, p_d, tgt;
    logic [IW-1:0]      bit_q, bit_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               e_neg_q, e_neg_d, spec_q, spec_d, sinv_q, sinv_d, sunf_q, sunf_d;
    logic               invalid_q, invalid_d, underflow_q, underflow_d;
    logic [PW-1:0]      prod;
    logic [N_W:0]       dtrial;
    logic signed [EW-1:0] e_s, qm_s, q_s;
    logic               sgn, ex_ones, ex_zero, mn_zero, le, lt, unused_bits;
`ifdef NROOT_ROUND_EN
    logic               lt_q, lt_d;

    function automatic logic [FPW-1:0] round_pack(input logic s, input logic [EXP_W-1:0] ex,
                                                  input logic [MAN_W:0] fr, input logic sticky);
        logic             up;
        logic [MAN_W:0]   sum;
        up  = fr[0] & (sticky | fr[1]);
        sum = {1'b0, fr[MAN_W:1]} + (MAN_W+1)'(up);
        // A carry out of the fraction leaves it zero and bumps the exponent
        return {s, ex + EXP_W'(sum[MAN_W]), sum[MAN_W-1:0]};
    endfunction
`else
    function automatic logic [FPW-1:0] trunc_pack(input logic s, input logic [EXP_W-1:0] ex,
                                                  input logic [MAN_W-1:0] fr);
        return {s, ex, fr};
    endfunction
`endif

    assign result    = result_q;
    assign invalid   = invalid_q;
    assign underflow = underflow_q;

    always_comb begin
        state_d = state_q;  a_d = a_q;      n_d = n_q;       sres_d = sres_q;
        spec_d = spec_q;    sinv_d = sinv_q; sunf_d = sunf_q; e_neg_d = e_neg_q;
        dq_d = dq_q;        rem_d = rem_q;  r_d = r_q;       qb_d = qb_q;
        y_d = y_q;          yt_d = yt_q;    p_d = p_q;       k_d = k_q;
        bit_d = bit_q;      cnt_d = cnt_q;
        result_d = result_q; invalid_d = invalid_q; underflow_d = underflow_q;
`ifdef NROOT_ROUND_EN
        lt_d = lt_q;
`endif
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        sgn     = a_q[FPW-1];
        ex_ones = &a_q[FPW-2:MAN_W];
        ex_zero = ~|a_q[FPW-2:MAN_W];
        mn_zero = ~|a_q[MAN_W-1:0];
        e_s     = $signed({1'b0, a_q[FPW-2:MAN_W]}) - $signed(EW'(BIAS));
        qm_s    = $signed({1'b0, dq_q});
        q_s     = qm_s;
        dtrial  = {rem_q, dq_q[EXP_W-1]};
        yt_c    = y_q | ((YF+1)'(1) << bit_q);
        prod    = PW'(p_q) * PW'(yt_q);
        unused_bits = ^prod[YF-1:0];
        tgt     = {1'b1, a_q[MAN_W-1:0], {(PF-MAN_W){1'b0}}};
        le      = (k_q < r_q) || ((k_q == r_q) && (p_q <= tgt));
        lt      = (k_q < r_q) || ((k_q == r_q) && (p_q < tgt));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d = A;  n_d = N;
                    invalid_d = 1'b0;  underflow_d = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                spec_d = 1'b1;  sinv_d = 1'b0;  sunf_d = 1'b0;  sres_d = QNAN;
                if (n_q == '0)                     sinv_d = 1'b1;
                else if (ex_ones && !mn_zero)      sinv_d = 1'b1;
                else if (ex_zero && !mn_zero) begin
                    sres_d = {sgn, {(FPW-1){1'b0}}};  sunf_d = 1'b1;
                end
                else if (ex_zero)                  sres_d = {sgn, {(FPW-1){1'b0}}};
                else if (sgn && !n_q[0])           sinv_d = 1'b1;
                else if (ex_ones)                  sres_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (n_q == N_W'(1))           sres_d = a_q;
                else                               spec_d = 1'b0;
                // Divide |e| unsigned, then fold the sign back in with floor semantics
                e_neg_d = e_s[EW-1];
                dq_d    = EXP_W'(e_s[EW-1] ? -e_s : e_s);
                rem_d   = '0;
                cnt_d   = CW'(EXP_W);
                state_d = spec_d ? S_PACK : S_DIVEXP;
            end
            S_DIVEXP: begin
                if (cnt_q != '0) begin
                    if (dtrial >= {1'b0, n_q}) begin
                        rem_d = N_W'(dtrial - {1'b0, n_q});
                        dq_d  = {dq_q[EXP_W-2:0], 1'b1};
                    end else begin
                        rem_d = dtrial[N_W-1:0];
                        dq_d  = {dq_q[EXP_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    r_d = rem_q;
                    if (e_neg_q && (rem_q == '0)) begin
                        q_s = -qm_s;
                    end else if (e_neg_q) begin
                        q_s = ~qm_s;
                        r_d = n_q - rem_q;
                    end
                    qb_d    = EXP_W'(q_s + $signed(EW'(BIAS)));
                    y_d     = {1'b1, {YF{1'b0}}};
                    bit_d   = IW'(YF - 1);
                    state_d = S_TRIAL;
                end
            end
            S_TRIAL: begin
                yt_d    = yt_c;
                p_d     = {yt_c, {(PF-YF){1'b0}}};
                k_d     = '0;
                cnt_d   = CW'(n_q) - CW'(1);
                state_d = S_MUL;
            end
            S_MUL: begin
                if (prod[PW-1]) begin
                    p_d = prod[PW-1:YF+1];
                    k_d = k_q + N_W'(1);
                end else begin
                    p_d = prod[PW-2:YF];
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_CMP;
            end
            S_CMP: begin
                if (le) y_d = yt_q;
`ifdef NROOT_ROUND_EN
                lt_d = lt;
`endif
                if (bit_q == '0) begin
                    state_d = S_PACK;
                end else begin
                    bit_d   = bit_q - IW'(1);
                    state_d = S_TRIAL;
                end
            end
            S_PACK: begin
`ifdef NROOT_ROUND_EN
                result_d = spec_q ? sres_q : round_pack(sgn, qb_q, y_q[YF-1:0], lt_q);
`else
                result_d = spec_q ? sres_q : trunc_pack(sgn, qb_q, y_q[YF-1:0]);
`endif
                invalid_d   = spec_q & sinv_q;
                underflow_d = spec_q & sunf_q;
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            invalid_q   <= invalid_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge CLK2) begin
        a_q <= a_d;     n_q <= n_d;       sres_q <= sres_d;   spec_q <= spec_d;
        sinv_q <= sinv_d; sunf_q <= sunf_d; e_neg_q <= e_neg_d; dq_q <= dq_d;
        rem_q <= rem_d; r_q <= r_d;       qb_q <= qb_d;       y_q <= y_d;
        yt_q <= yt_d;   p_q <= p_d;       k_q <= k_d;         bit_q <= bit_d;
        cnt_q <= cnt_d;
`ifdef NROOT_ROUND_EN
        lt_q <= lt_d;
`endif
    end
endmodule
